logreplay: RTL

LOGREPLAY -- requirements
Module: logreplay

---
 rtl/logchange_pkg.sv | 10 +
 rtl/logword_assemble.sv | 44 ++++
 rtl/logreplay.sv | 88 ++++++++
 3 files changed

// File: rtl/logchange_pkg.sv
// Shared record-format definitions for the signal logger and its replay block.
package logchange_pkg;
  localparam int NSIG = 12;
  localparam int NBYTES = (NSIG + 8) / 8;
  localparam int TAG_BIT = NSIG;
  localparam logic [NSIG:0] MARKER_WORD = '1;
  localparam logic [NSIG:0] END_WORD = '0;

  typedef enum logic [1:0] {COLLECT, WAIT, MARK, HALT} state_e;
endpackage

// File: rtl/logword_assemble.sv
// Byte-stream handshake and LSB-first assembly of one NSIG+1 bit record word.
module logword_assemble #(
  parameter int NSIG = 12,
  parameter int NBYTES = (NSIG + 8) / 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_next,
  output logic [NSIG:0] word,
  output logic          word_valid
);
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  // Holds all bytes but the last; the last byte is used straight from the bus.
  // NSIG >= 8 is assumed so there is always at least one held byte.
  logic [8*(NBYTES-1)-1:0] shreg;
  logic [IW-1:0]           idx;
  logic                    capture;

  assign capture    = enable && in_valid && !in_next;
  assign word_valid = capture && (idx == IW'(NBYTES - 1));
  assign word       = (NSIG + 1)'({in_data, shreg});

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      shreg   <= '0;
      in_next <= 1'b0;
    end else begin
      in_next <= capture;
      if (capture) begin
        if (word_valid) begin
          idx <= '0;
        end else begin
          shreg[8*idx +: 8] <= in_data;
          idx <= idx + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/logreplay.sv
// Replays a captured signal log: applies samples, honours timestamp delays,
// and stops on the end-of-capture marker.
module logreplay #(
  parameter int NSIG = logchange_pkg::NSIG
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [7:0]      in_data,
  output logic            in_next,
  output logic [NSIG-1:0] sig_out,
  output logic            sig_strobe,
  output logic            overflow,
  output logic            proto_err,
  output logic            halted
);
  import logchange_pkg::*;

  localparam int NBYTES = (NSIG + 8) / 8;

  state_e          state, state_nx;
  logic [NSIG-1:0] cnt;
  logic [NSIG:0]   word;
  logic            word_valid;
  logic [NSIG-1:0] payload;
  logic            tag;
  logic            all_ones;

  assign payload  = word[NSIG-1:0];
  assign tag      = word[NSIG];
  assign all_ones = &payload;

  logword_assemble #(.NSIG(NSIG), .NBYTES(NBYTES)) u_asm (
    .clk        (clk),
    .rst        (rst),
    .enable     (state == COLLECT || state == MARK),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_next    (in_next),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_nx = state;
    case (state)
      COLLECT: if (word_valid && tag) begin
        if (all_ones)           state_nx = MARK;
        else if (payload != '0) state_nx = WAIT;
      end
      WAIT:    if (cnt == NSIG'(1)) state_nx = COLLECT;
      MARK:    if (word_valid) state_nx = HALT;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= COLLECT;
      cnt        <= '0;
      sig_out    <= '0;
      sig_strobe <= 1'b0;
      overflow   <= 1'b0;
      proto_err  <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state      <= state_nx;
      sig_strobe <= 1'b0;
      halted     <= (state_nx == HALT);
      case (state)
        COLLECT: if (word_valid) begin
          if (!tag) begin
            sig_out    <= payload;
            sig_strobe <= 1'b1;
          end else if (!all_ones) begin
            cnt <= payload;
          end
        end
        WAIT: cnt <= cnt - 1'b1;
        MARK: if (word_valid) begin
          overflow  <= (word == '0);
          proto_err <= (word != '0);
        end
        default: ;
      endcase
    end
  end
endmodule
